sha3_pad_absorber: RTL and testbench

- Streaming front-end for the keccak core. Accepts an arbitrary-length byte message over a valid/ready beat interface, IN_BYTES bytes per beat.
- Packs beats into rate-sized blocks and applies SHA-3/SHAKE pad10*1 with a configurable domain suffix.
- Presents complete blocks to the keccak message input over a second valid/ready handshake.
- Replaces bench-side padding and supports back-to-back messages.

---
 rtl/sha3_pad_absorber_if.sv | 31 +++
 rtl/sha3_pad_absorber.sv | 162 ++++++++++++++++
 tb/tb_sha3_pad_absorber.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_pad_absorber_if.sv
// Beat-in / block-out handshake bundle for the SHA-3 pad absorber.
// The slave modport is the absorber itself and the master modport is whoever
// feeds messages and consumes blocks.
interface sha3_pad_absorber_if #(
  parameter int IN_BYTES = 8,
  parameter int R        = 576
);
  // Message beat stream
  logic [8*IN_BYTES-1:0]         in_data;
  logic [$clog2(IN_BYTES+1)-1:0] in_keep;
  logic                          in_last;
  logic                          in_valid;
  logic                          in_ready;

  // Rate-sized block stream towards the keccak core
  logic [R-1:0]                  blk_data;
  logic                          blk_first;
  logic                          blk_last;
  logic                          blk_valid;
  logic                          blk_ready;

  modport slave (
    input  in_data, in_keep, in_last, in_valid, blk_ready,
    output in_ready, blk_data, blk_first, blk_last, blk_valid
  );

  modport master (
    output in_data, in_keep, in_last, in_valid, blk_ready,
    input  in_ready, blk_data, blk_first, blk_last, blk_valid
  );
endinterface

// File: rtl/sha3_pad_absorber.sv
// SHA-3 / SHAKE streaming front-end: packs byte beats into rate-sized blocks,
// applies pad10*1 with a domain suffix and hands whole blocks to keccak.
// An exactly rate-aligned message is followed by a pad-only block.
module sha3_pad_absorber #(
  parameter int          D        = 512,
  parameter int          IN_BYTES = 8,
  parameter logic [7:0]  SUFFIX   = 8'h06
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sha3_pad_absorber_if.slave   bus
);

  localparam int R  = 1600 - 2*D;
  localparam int RB = R / 8;
  localparam int CW = $clog2(RB + 1);
  localparam int AW = $clog2(RB);

  // Packing only works when beats tile the block exactly.
  if ((RB % IN_BYTES) != 0) begin : g_bad_beat_width
    $error("sha3_pad_absorber: rate bytes must be a multiple of IN_BYTES");
  end

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PADBLK
  } state_e;

  // Byte 0 occupies the MSBs, so the buffer maps directly onto blk_data.
  typedef logic [0:RB-1][7:0] block_t;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  block_t         buf_q, buf_d;
  logic           pend_q, pend_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic           ready_q, ready_d;
  logic           accept;

  assign accept  = bus.in_valid & ready_q;
  assign ready_d = (state_d == FILL);

  // Next-state logic: byte packing, padding and block handoff.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    pend_d  = pend_q;
    first_d = first_q;
    last_d  = last_q;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          // NOTE: blocking assignments here so the pad step below sees the
          // bytes written by this same beat.
          for (int i = 0; i < IN_BYTES; i++) begin
            logic [8*IN_BYTES-1:0] shifted;
            shifted = bus.in_data << (8*i);
            if ((i < int'(bus.in_keep)) && ((int'(cnt_q) + i) < RB)) begin
              buf_d[AW'(int'(cnt_q) + i)] = shifted[8*IN_BYTES-1 -: 8];
            end
          end

          if (!bus.in_last) begin
            if ((int'(cnt_q) + IN_BYTES) >= RB) begin
              cnt_d   = '0;
              last_d  = 1'b0;
              state_d = EMIT;
            end else begin
              cnt_d = cnt_q + CW'(IN_BYTES);
            end
          end else if ((int'(cnt_q) + int'(bus.in_keep)) < RB) begin
            // Room for the suffix: pad inside this block and finish here.
            for (int j = 0; j < RB; j++) begin
              if (j == (int'(cnt_q) + int'(bus.in_keep))) begin
                buf_d[AW'(j)] = SUFFIX;
              end
            end
            buf_d[RB-1] = buf_d[RB-1] | 8'h80;
            cnt_d       = '0;
            last_d      = 1'b1;
            state_d     = EMIT;
          end else begin
            // Block is full of message bytes; padding needs its own block.
            cnt_d   = '0;
            last_d  = 1'b0;
            pend_d  = 1'b1;
            state_d = EMIT;
          end
        end
      end

      EMIT: begin
        if (bus.blk_ready) begin
          buf_d   = '0;
          first_d = 1'b0;
          if (pend_q) begin
            buf_d[0]    = SUFFIX;
            buf_d[RB-1] = 8'h80;
            state_d     = PADBLK;
          end else begin
            if (last_q) begin
              first_d = 1'b1;
            end
            state_d = FILL;
          end
        end
      end

      PADBLK: begin
        if (bus.blk_ready) begin
          buf_d   = '0;
          pend_d  = 1'b0;
          first_d = 1'b1;
          state_d = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State registers; reset discards any partial block and pending pad.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      // NOTE: the buffer is reset because padding relies on unfilled bytes
      // already being zero, and blk_data must read zero out of reset.
      buf_q   <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  // Output decode; data and flags are register-held while a block waits.
  always_comb begin
    bus.in_ready  = ready_q;
    bus.blk_data  = buf_q;
    bus.blk_valid = (state_q == EMIT) || (state_q == PADBLK);
    bus.blk_first = (state_q == EMIT) && first_q;
    bus.blk_last  = ((state_q == EMIT) && last_q) || (state_q == PADBLK);
  end

endmodule

// File: tb/tb_sha3_pad_absorber.sv
// Directed bench for sha3_pad_absorber (D=512, IN_BYTES=8, SHA-3 suffix).
// Message vectors are table-driven; reset recovery and first-block latency
// are hand-written sequences.
module tb_sha3_pad_absorber;

  localparam int IN_BYTES = 8;
  localparam int R        = 576;
  localparam int RB       = 72;
  localparam int KW       = $clog2(IN_BYTES + 1);
  localparam int TIMEOUT  = 400;

  typedef logic [0:RB-1][7:0] blk_t;

  typedef struct {
    string      name;
    int         len;       // message length in bytes
    logic [7:0] base;      // message byte k = base + k
    int         nblk;      // expected block count
    int         pad_pos;   // byte of the final block holding the suffix
    logic [7:0] pad_val;   // expected value at pad_pos
    logic [7:0] last_val;  // expected value at byte RB-1 of the final block
    int         stall;     // cycles blk_ready is held low on block 0
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  sha3_pad_absorber_if #(.IN_BYTES(IN_BYTES), .R(R)) bus ();

  sha3_pad_absorber #(.D(512), .IN_BYTES(IN_BYTES), .SUFFIX(8'h06)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal beats are outside the design contract; flag them if driven.
  always @(posedge clk) begin
    if (reset_n && bus.in_valid && bus.in_ready) begin
      assert (bus.in_keep <= KW'(IN_BYTES) &&
              (bus.in_last || bus.in_keep == KW'(IN_BYTES)))
        else $error("illegal input beat keep=%0d last=%0b", bus.in_keep, bus.in_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [R-1:0] act, input logic [R-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out after %0d cycles, got none expected handshake", name, TIMEOUT);
  endtask

  function automatic blk_t exp_block(input vec_t v, input int b);
    blk_t e;
    int   rem;
    e = '0;
    if (b < v.nblk - 1) begin
      for (int k = 0; k < RB; k++) e[k] = v.base + 8'(RB*b + k);
    end else begin
      rem = v.len - RB*(v.nblk - 1);
      for (int k = 0; k < rem; k++) e[k] = v.base + 8'(RB*b + k);
      e[v.pad_pos] = v.pad_val;
      e[RB-1]      = v.last_val;
    end
    return e;
  endfunction

  // Drive one message; caller starts on a falling edge.
  task automatic send_msg(input vec_t v);
    int beats;
    int keep;
    int n;
    logic [8*IN_BYTES-1:0] d;
    beats = (v.len == 0) ? 1 : (v.len + IN_BYTES - 1) / IN_BYTES;
    for (int bt = 0; bt < beats; bt++) begin
      keep = (bt == beats - 1) ? (v.len - IN_BYTES*bt) : IN_BYTES;
      d = '0;
      for (int i = 0; i < keep; i++) d[8*(IN_BYTES-i)-1 -: 8] = v.base + 8'(IN_BYTES*bt + i);
      bus.in_data  = d;
      bus.in_keep  = KW'(keep);
      bus.in_last  = (bt == beats - 1);
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < TIMEOUT) begin
        @(negedge clk);
        n++;
      end
      if (n >= TIMEOUT) begin
        timeout_fail({v.name, "_send"});
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Receive and check every block of one message.
  task automatic collect(input vec_t v);
    int          n;
    logic        ok;
    logic [R-1:0] held;
    for (int b = 0; b < v.nblk; b++) begin
      n = 0;
      while (!bus.blk_valid && n < TIMEOUT) begin
        @(negedge clk);
        n++;
      end
      if (n >= TIMEOUT) begin
        timeout_fail($sformatf("%s_blk%0d", v.name, b));
        return;
      end
      check($sformatf("%s_blk%0d_data", v.name, b), bus.blk_data, exp_block(v, b));
      check($sformatf("%s_blk%0d_first", v.name, b), R'(bus.blk_first), R'(b == 0));
      check($sformatf("%s_blk%0d_last", v.name, b), R'(bus.blk_last), R'(b == v.nblk - 1));
      if (b == 0 && v.stall > 0) begin
        held = bus.blk_data;
        ok   = !bus.in_ready;
        for (int s = 0; s < v.stall; s++) begin
          @(negedge clk);
          if (!bus.blk_valid || bus.blk_data !== held || bus.in_ready) ok = 1'b0;
        end
        check($sformatf("%s_backpressure_hold", v.name), R'(ok), R'(1'b1));
      end
      bus.blk_ready = 1'b1;
      @(negedge clk);
      bus.blk_ready = 1'b0;
    end
  endtask

  vec_t vecs[8];
  vec_t abc;

  initial begin
    checks   = 0;
    failures = 0;
    //            name        len  base   nblk pad  pval   lval   stall
    vecs[0] = '{"empty",      0,   8'h00, 1,   0,   8'h06, 8'h80, 0};
    vecs[1] = '{"abc",        3,   8'h61, 1,   3,   8'h06, 8'h80, 0};
    vecs[2] = '{"len71",      71,  8'h00, 1,   71,  8'h86, 8'h86, 0};
    vecs[3] = '{"len72",      72,  8'h00, 2,   0,   8'h06, 8'h80, 0};
    vecs[4] = '{"len70",      70,  8'h10, 1,   70,  8'h06, 8'h80, 0};
    vecs[5] = '{"len9",       9,   8'hA0, 1,   9,   8'h06, 8'h80, 0};
    vecs[6] = '{"len144",     144, 8'h30, 3,   0,   8'h06, 8'h80, 0};
    vecs[7] = '{"abc_bp",     3,   8'h61, 1,   3,   8'h06, 8'h80, 10};
    abc     = vecs[1];

    reset_n       = 1'b0;
    bus.in_data   = '0;
    bus.in_keep   = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.blk_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready",  R'(bus.in_ready),  R'(1'b0));
    check("rst_blk_valid", R'(bus.blk_valid), R'(1'b0));
    check("rst_blk_first", R'(bus.blk_first), R'(1'b0));
    check("rst_blk_last",  R'(bus.blk_last),  R'(1'b0));
    check("rst_blk_data",  bus.blk_data,      '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back messages from the vector table.
    for (int i = 0; i < 8; i++) begin
      fork
        send_msg(vecs[i]);
        collect(vecs[i]);
      join
    end
    repeat (5) @(negedge clk);
    check("idle_no_block", R'(bus.blk_valid), R'(1'b0));

    // Abort a message after four beats with a mid-stream reset.
    for (int bt = 0; bt < 4; bt++) begin
      bus.in_data  = {8{8'hEE}};
      bus.in_keep  = KW'(IN_BYTES);
      bus.in_last  = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("partial_no_block", R'(bus.blk_valid), R'(1'b0));
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready",  R'(bus.in_ready),  R'(1'b0));
    check("midrst_blk_data",  bus.blk_data,      '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // "abc" after the abort: block appears the cycle after the beat.
    check("post_rst_in_ready", R'(bus.in_ready), R'(1'b1));
    bus.in_data  = {8'h61, 8'h62, 8'h63, 40'h0};
    bus.in_keep  = KW'(3);
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("latency_blk_valid", R'(bus.blk_valid), R'(1'b1));
    check("abc_literal", bus.blk_data,
          {8'h61, 8'h62, 8'h63, 8'h06, {67{8'h00}}, 8'h80});
    collect(abc);
    repeat (5) @(negedge clk);
    check("final_no_block", R'(bus.blk_valid), R'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
